freq_div_prog: RTL and testbench
================================

FREQ_DIV_PROG -- requirements
Module: freq_div_prog

Interface
REQ-001 Parameter WIDTH, default 8: divisor width in bits (legal 2..16).
REQ-002 Parameter RST_DIV, default 10: divisor active after reset (legal 1..2^WIDTH-1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 en  input  1  count enable; 0 = hold.
REQ-006 clr  input  1  synchronous restart of the current period.
REQ-007 load  input  1  one-cycle strobe; samples div_in.
REQ-008 div_in  input  WIDTH  requested divisor N (unsigned).
REQ-009 Q  output  1  divided clock, registered.
REQ-010 tick  output  1  one-cycle pulse per completed period, registered.
REQ-011 pending  output  1  a loaded divisor is waiting to take effect.
REQ-012 div_err  output  1  sticky: a load with div_in==0 was rejected.

Function
REQ-013 Internal state SHALL be: cnt (WIDTH bits), active divisor N_act, pending divisor N_pend, pending flag, Q, tick, div_err.
REQ-014 With en=1, clr=0: cnt SHALL go 0,1,...,N_act-1,0 (wrap when cnt==N_act-1); period = N_act cycles.
REQ-015 Q SHALL equal (cnt >= floor(N_act/2)) registered alongside cnt: low phase floor(N/2) cycles first, then high phase ceil(N/2) cycles (exact 50% for even N; odd N has high phase one cycle longer).
REQ-016 N_act==1: Q SHALL be held 1 and tick SHALL be 1 every enabled cycle.
REQ-017 tick SHALL be 1 for exactly one cycle, the cycle after a wrap edge (cnt==0, coincident with Q falling for N_act>=2); never asserted in the first period after reset or clr.
REQ-018 en=0: cnt, Q SHALL hold; tick SHALL be 0; load still accepted.
REQ-019 load with div_in>=1: N_pend<=div_in, pending<=1, div_err<=0; repeated load while pending overwrites N_pend (last wins).
REQ-020 load with div_in==0: N_pend and pending unchanged; div_err<=1, held until reset or a valid load.
REQ-021 Pending divisor SHALL take effect at the next wrap edge: N_act<=N_pend, pending<=0, cnt<=0; Q/halving follow the new N_act from that edge.
REQ-022 load in the same cycle as a wrap edge: the old N_pend (if any) applies at this wrap; the new value becomes pending for the following wrap.
REQ-023 clr=1 (priority over en and wrap): cnt<=0, Q<=0, tick<=0; if pending, N_act<=N_pend and pending<=0 immediately; a load in the same cycle is captured as pending afterwards.
REQ-024 No output glitch: Q and tick SHALL be driven only from flops.

Reset
REQ-025 rst=1 SHALL asynchronously force cnt=0, Q=0, tick=0, pending=0, div_err=0, N_act=RST_DIV, N_pend=RST_DIV.
REQ-026 Reset release SHALL be usable mid-operation; first counting edge after release is the first enabled rising clk.

Structure
REQ-027 Shared package freq_div_pkg SHALL hold the default WIDTH and RST_DIV constants and the halving function floor(N/2).
REQ-028 The counter/wrap logic SHALL be one sub-module, div_counter (cnt, wrap flag, en, clr, async rst); divisor bookkeeping and Q/tick stay in the top.

Verification
REQ-029 Reset, en=1, defaults (N=10): Q low 5 cycles, high 5 cycles repeating; first tick at cycle 10 after release, then every 10.
REQ-030 load div_in=5 mid-period: pending=1 until the wrap, then period 5 with Q low 2 / high 3, tick every 5; pending=0.
REQ-031 load div_in=0: div_err=1, divisor unchanged; next load div_in=4 clears div_err, period 4 (2/2) after next wrap.
REQ-032 loads 7 then 3 before a wrap: period after wrap is 3 (last wins); N=1 load gives Q=1 constant and tick every cycle.
REQ-033 en toggled low for 3 cycles mid-high-phase: Q and cnt frozen, no tick; high phase resumes with correct remaining length.
REQ-034 clr asserted with pending=6 and rst pulsed asynchronously between clock edges: clr restarts at cnt=0 with N=6 immediately; rst clears all outputs without a clock edge.

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the programmable frequency divider.
package freq_div_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_RST_DIV = 10;

    // Length of the low phase for divisor n: floor(n/2).
    function automatic logic [15:0] half_div(input logic [15:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/freq_div_prog_if.sv
// Control and status bundle of the programmable divider.
interface freq_div_prog_if import freq_div_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             en;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] div_in;
    logic             Q;
    logic             tick;
    logic             pending;
    logic             div_err;

    modport master (
        output en, clr, load, div_in,
        input  Q, tick, pending, div_err
    );

    modport slave (
        input  en, clr, load, div_in,
        output Q, tick, pending, div_err
    );

endinterface

// File: rtl/div_counter.sv
// Period counter: counts 0..n_act-1 while enabled and flags the wrap edge.
module div_counter import freq_div_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] n_act,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Wrap happens on an enabled edge at the last count, unless clr overrides.
    assign wrap = en & ~clr & (cnt == (n_act - ONE));

    // Count register: clr restarts, wrap returns to zero, en=0 holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/freq_div_prog.sv
// Programmable clock divider with glitch-free registered Q/tick and
// divisor changes deferred to the period boundary.
module freq_div_prog import freq_div_pkg::*; #(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int RST_DIV = DEF_RST_DIV
) (
    input  logic          clk,
    input  logic          rst,
    freq_div_prog_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_N = WIDTH'(RST_DIV);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] n_act;
    logic [WIDTH-1:0] n_pend;
    logic [WIDTH-1:0] n_next;
    logic [WIDTH-1:0] half_act;
    logic             wrap;
    logic             restart;
    logic             load_ok;
    logic             pending_r;
    logic             div_err_r;
    logic             q_r;
    logic             tick_r;
    logic             q_next;

    div_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.en),
        .clr   (bus.clr),
        .n_act (n_act),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    assign load_ok  = bus.load & (bus.div_in != '0);
    assign restart  = bus.clr | wrap;
    // Divisor in force right after a wrap or clr: the pending one if any.
    assign n_next   = pending_r ? n_pend : n_act;
    assign half_act = WIDTH'(half_div(16'(n_act)));

    // Q follows the count it will sit beside after this edge.
    always_comb begin
        q_next = q_r;
        if (bus.clr) begin
            q_next = 1'b0;
        end else if (wrap) begin
            // Fresh period at cnt=0: only high when the new divisor is 1.
            q_next = (n_next == ONE);
        end else if (bus.en) begin
            q_next = ((cnt + ONE) >= half_act);
        end
    end

    // Divisor bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_act     <= RST_N;
            n_pend    <= RST_N;
            pending_r <= 1'b0;
            div_err_r <= 1'b0;
            q_r       <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            q_r    <= q_next;
            tick_r <= wrap;
            if (restart && pending_r) begin
                n_act <= n_pend;
            end
            // A load in the same cycle as a restart queues for the next one.
            if (load_ok) begin
                n_pend    <= bus.div_in;
                pending_r <= 1'b1;
                div_err_r <= 1'b0;
            end else begin
                if (bus.load) begin
                    div_err_r <= 1'b1;
                end
                if (restart) begin
                    pending_r <= 1'b0;
                end
            end
        end
    end

    assign bus.Q       = q_r;
    assign bus.tick    = tick_r;
    assign bus.pending = pending_r;
    assign bus.div_err = div_err_r;

endmodule

// File: tb/tb_freq_div_prog.sv
// Self-checking bench for freq_div_prog: per-cycle scoreboard against a
// behavioural model, table of phase-length vectors, hand-written corners.
`timescale 1ns/1ps
module tb_freq_div_prog;
    import freq_div_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic q;
        logic tick;
        logic pending;
        logic err;
    } obs_t;

    typedef struct {
        int div;
        int lo;
        int hi;
    } phase_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    freq_div_prog_if #(.WIDTH(W)) bus ();

    freq_div_prog #(.WIDTH(W), .RST_DIV(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    obs_t exp_q[$];

    int   m_cnt, m_n, m_np;
    logic m_pend, m_q, m_tick, m_err;

    phase_vec_t tbl[7];

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic drive(input logic en, input logic clr, input logic load, input int div);
        bus.en     = en;
        bus.clr    = clr;
        bus.load   = load;
        bus.div_in = W'(div);
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_n    = 10;
        m_np   = 10;
        m_pend = 1'b0;
        m_q    = 1'b0;
        m_tick = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge();
        logic wrap;
        wrap = bus.en && !bus.clr && (m_cnt == m_n - 1);
        if (bus.clr) begin
            if (m_pend) begin
                m_n    = m_np;
                m_pend = 1'b0;
            end
            m_cnt  = 0;
            m_q    = 1'b0;
            m_tick = 1'b0;
        end else if (bus.en) begin
            if (wrap) begin
                m_cnt = 0;
                if (m_pend) begin
                    m_n    = m_np;
                    m_pend = 1'b0;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
            m_q    = (m_cnt >= m_n / 2);
            m_tick = wrap;
        end else begin
            m_tick = 1'b0;
        end
        if (bus.load) begin
            if (bus.div_in != 0) begin
                m_np   = int'(bus.div_in);
                m_pend = 1'b1;
                m_err  = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        obs_t a;
        obs_t e;
        @(posedge clk);
        model_edge();
        exp_q.push_back('{m_q, m_tick, m_pend, m_err});
        #1;
        a = '{bus.Q, bus.tick, bus.pending, bus.div_err};
        e = exp_q.pop_front();
        check("step{q,tick,pend,err}", int'(a), int'(e));
    endtask

    task automatic tick_gap(input string name, input int want);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!bus.tick && n < 64);
        check(name, n, want);
    endtask

    task automatic wait_pending_clear();
        int n;
        n = 0;
        while (bus.pending && n < 64) begin
            cycle();
            n++;
        end
        check("pending_clear", int'(bus.pending), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, hi, mid_ticks, n;

        tbl[0] = '{5, 2, 3};
        tbl[1] = '{4, 2, 2};
        tbl[2] = '{7, 3, 4};
        tbl[3] = '{3, 1, 2};
        tbl[4] = '{2, 1, 1};
        tbl[5] = '{1, 0, 1};
        tbl[6] = '{10, 5, 5};

        drive(1, 0, 0, 0);
        model_reset();
        #2;
        check("reset_state", int'({bus.Q, bus.tick, bus.pending, bus.div_err}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Default divisor 10 after reset.
        tick_gap("first_tick", 10);
        tick_gap("tick_period10", 10);

        // Phase lengths for each divisor, low phase first.
        foreach (tbl[i]) begin
            drive(1, 0, 1, tbl[i].div);
            cycle();
            drive(1, 0, 0, 0);
            wait_pending_clear();
            lo = 0;
            hi = 0;
            mid_ticks = 0;
            for (int k = 0; k < tbl[i].div; k++) begin
                if (k > 0) begin
                    cycle();
                    if (bus.tick) mid_ticks++;
                end
                if (bus.Q) hi++;
                else lo++;
            end
            cycle();
            check($sformatf("low_len_n%0d", tbl[i].div), lo, tbl[i].lo);
            check($sformatf("high_len_n%0d", tbl[i].div), hi, tbl[i].hi);
            check($sformatf("mid_ticks_n%0d", tbl[i].div), mid_ticks, 0);
            check($sformatf("end_tick_n%0d", tbl[i].div), int'(bus.tick), 1);
        end

        // Rejected zero load, then valid load of 4.
        drive(1, 0, 1, 0);
        cycle();
        check("err_set", int'(bus.div_err), 1);
        check("err_no_pending", int'(bus.pending), 0);
        drive(1, 0, 1, 4);
        cycle();
        drive(1, 0, 0, 0);
        check("err_cleared", int'(bus.div_err), 0);
        wait_pending_clear();
        tick_gap("period4", 4);

        // Last load before the wrap wins.
        drive(1, 0, 1, 7);
        cycle();
        drive(1, 0, 1, 3);
        cycle();
        drive(1, 0, 0, 0);
        wait_pending_clear();
        tick_gap("last_wins_period3", 3);

        // en low for 3 cycles in the high phase of N=8.
        drive(1, 0, 1, 8);
        cycle();
        drive(1, 0, 0, 0);
        wait_pending_clear();
        repeat (5) cycle();
        drive(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("hold_q", int'(bus.Q), 1);
            check("hold_tick", int'(bus.tick), 0);
        end
        drive(1, 0, 0, 0);
        tick_gap("resume_remaining", 3);

        // Load coinciding with the wrap edge: older pending value applies first.
        drive(1, 0, 1, 2);
        cycle();
        drive(1, 0, 0, 0);
        n = 0;
        while (m_cnt != m_n - 1 && n < 64) begin
            cycle();
            n++;
        end
        drive(1, 0, 1, 5);
        cycle();
        drive(1, 0, 0, 0);
        check("wrap_load_pending", int'(bus.pending), 1);
        tick_gap("wrap_load_old_first", 2);
        tick_gap("wrap_load_new_next", 5);

        // clr with pending 6 applies it immediately.
        drive(1, 0, 1, 6);
        cycle();
        drive(1, 1, 0, 0);
        cycle();
        check("clr_pending_taken", int'(bus.pending), 0);
        check("clr_q_low", int'(bus.Q), 0);
        drive(1, 0, 0, 0);
        tick_gap("clr_period6", 6);

        // clr with a simultaneous load: load becomes pending afterwards.
        drive(1, 1, 1, 3);
        cycle();
        drive(1, 0, 0, 0);
        check("clr_load_pending", int'(bus.pending), 1);
        tick_gap("clr_load_keep6", 6);
        tick_gap("clr_load_then3", 3);

        // Asynchronous reset between clock edges.
        drive(1, 0, 1, 9);
        cycle();
        drive(1, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", int'({bus.Q, bus.tick, bus.pending, bus.div_err}), 0);
        model_reset();
        #1;
        rst = 1'b0;
        tick_gap("post_reset_period10", 10);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 12)));
            cycle();
        end
        drive(1, 0, 0, 0);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
